// File: rtl/dda_host_ctrl.sv
// Byte-serial host controller for a DDA integrator: register writes, run control, state frame readout.
// Optional continuous streaming of state frames when DDA_CTRL_STREAM_EN is defined.
module dda_host_ctrl #(
  parameter int unsigned N        = 16,
  parameter int unsigned REG_SIZE = 14,
  parameter int unsigned OUT_SIZE = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            tx_byte,
  input  logic [N-1:0]          x,
  input  logic [N-1:0]          y,
  input  logic [N-1:0]          z,
  output logic [8*REG_SIZE-1:0] params,
  output logic                  dda_en,
  output logic                  dda_init,
  output logic                  err
);

  localparam int unsigned PW     = 8 * REG_SIZE;
  localparam int unsigned SNAP_W = 3 * N;
  localparam int unsigned IDX_W  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_P = 8'h50;
  localparam logic [7:0] CMD_I = 8'h49;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_E = 8'h45;
`ifdef DDA_CTRL_STREAM_EN
  localparam logic [7:0] CMD_C = 8'h43;
`endif

  typedef enum logic [1:0] {IDLE, ADDR, DATA, SEND} state_e;

  // Power-on coefficients: initial conditions, sigma, beta, rho, dt
  function automatic logic [7:0] reset_byte(input int unsigned i);
    case (i)
      0:       reset_byte = 8'hC0;
      2:       reset_byte = 8'h14;
      3:       reset_byte = 8'hCD;
      4:       reset_byte = 8'h72;
      5:       reset_byte = 8'h40;
      6:       reset_byte = 8'h6A;
      8:       reset_byte = 8'h55;
      9:       reset_byte = 8'h55;
      10:      reset_byte = 8'h73;
      12:      reset_byte = 8'h04;
      default: reset_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [PW-1:0] params_rst();
    logic [PW-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < REG_SIZE; i++) v[i*8 +: 8] = reset_byte(i);
    return v;
  endfunction

  // Byte k of a frame, most significant byte of x first
  function automatic logic [7:0] frame_byte(input logic [SNAP_W-1:0] s, input logic [IDX_W-1:0] k);
    logic [7:0] b;
    b = 8'h00;
    for (int unsigned i = 0; i < OUT_SIZE; i++)
      if (IDX_W'(i) == k) b = s[(OUT_SIZE-1-i)*8 +: 8];
    return b;
  endfunction

  state_e            state_q, state_d;
  logic [7:0]        addr_q, addr_d;
  logic [PW-1:0]     params_q, params_d;
  logic              dda_en_q, dda_en_d;
  logic              dda_init_q, dda_init_d;
  logic              err_q, err_d;
  logic [SNAP_W-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [SNAP_W-1:0] cap_c;
  logic              capture_c;
`ifdef DDA_CTRL_STREAM_EN
  logic              stream_q, stream_d;
`endif

  assign cap_c = {x, y, z};

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    params_d   = params_q;
    dda_en_d   = dda_en_q;
    dda_init_d = 1'b0;
    err_d      = err_q;
    snap_d     = snap_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    tx_byte_d  = tx_byte_q;
    capture_c  = 1'b0;
`ifdef DDA_CTRL_STREAM_EN
    stream_d   = stream_q;
`endif

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_byte)
            CMD_W:   state_d    = ADDR;
            CMD_S:   dda_en_d   = 1'b1;
            CMD_P:   dda_en_d   = 1'b0;
            CMD_I:   dda_init_d = 1'b1;
            CMD_R:   capture_c  = 1'b1;
            CMD_E:   err_d      = 1'b0;
`ifdef DDA_CTRL_STREAM_EN
            CMD_C:   stream_d   = ~stream_q;
`endif
            default: err_d      = 1'b1;
          endcase
        end
`ifdef DDA_CTRL_STREAM_EN
        else if (stream_q && dda_en_q) begin
          capture_c = 1'b1;
        end
`endif
      end
      ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_byte;
          state_d = DATA;
        end
      end
      DATA: begin
        if (rx_valid) begin
          // Out-of-range addresses still consume the data byte
          if (32'(addr_q) < REG_SIZE) begin
            for (int unsigned i = 0; i < REG_SIZE; i++)
              if (8'(i) == addr_q) params_d[i*8 +: 8] = rx_byte;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      SEND: begin
        if (rx_valid) begin
`ifdef DDA_CTRL_STREAM_EN
          // While streaming, the run-control bytes must still get through
          if (stream_q && rx_byte == CMD_P)      dda_en_d = 1'b0;
          else if (stream_q && rx_byte == CMD_C) stream_d = 1'b0;
          else                                   err_d    = 1'b1;
`else
          err_d = 1'b1;
`endif
        end
        if (tx_valid_q && tx_ready) begin
          if (idx_q == IDX_W'(OUT_SIZE - 1)) begin
            tx_valid_d = 1'b0;
            state_d    = IDLE;
`ifdef DDA_CTRL_STREAM_EN
            if (stream_d && dda_en_d) capture_c = 1'b1;
`endif
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_byte_d = frame_byte(snap_q, idx_q + IDX_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // New frame: snapshot taken on this edge, first byte presented next cycle
    if (capture_c) begin
      snap_d     = cap_c;
      idx_d      = '0;
      tx_byte_d  = frame_byte(cap_c, '0);
      tx_valid_d = 1'b1;
      state_d    = SEND;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= 8'h00;
      params_q   <= params_rst();
      dda_en_q   <= 1'b1;
      dda_init_q <= 1'b0;
      err_q      <= 1'b0;
      snap_q     <= '0;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= 8'h00;
`ifdef DDA_CTRL_STREAM_EN
      stream_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      params_q   <= params_d;
      dda_en_q   <= dda_en_d;
      dda_init_q <= dda_init_d;
      err_q      <= err_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      tx_byte_q  <= tx_byte_d;
`ifdef DDA_CTRL_STREAM_EN
      stream_q   <= stream_d;
`endif
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_byte  = tx_byte_q;
  assign params   = params_q;
  assign dda_en   = dda_en_q;
  assign dda_init = dda_init_q;
  assign err      = err_q;

endmodule

// File: tb/tb_dda_host_ctrl.sv
// Randomized self-checking bench for dda_host_ctrl against a byte-level protocol model.
module tb_dda_host_ctrl;

  localparam int unsigned N        = 16;
  localparam int unsigned REG_SIZE = 14;
  localparam int unsigned OUT_SIZE = 6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  rx_valid;
  logic [7:0]            rx_byte;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            tx_byte;
  logic [N-1:0]          x, y, z;
  logic [8*REG_SIZE-1:0] params_w;
  logic                  dda_en, dda_init, err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] m_params [REG_SIZE];
  logic       m_err;
  logic       m_en;

  dda_host_ctrl #(.N(N), .REG_SIZE(REG_SIZE), .OUT_SIZE(OUT_SIZE)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_byte(tx_byte),
    .x(x), .y(y), .z(z), .params(params_w),
    .dda_en(dda_en), .dda_init(dda_init), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    logic [7:0] d [14] = '{8'hC0, 8'h00, 8'h14, 8'hCD, 8'h72, 8'h40, 8'h6A,
                           8'h00, 8'h55, 8'h55, 8'h73, 8'h00, 8'h04, 8'h00};
    for (int i = 0; i < REG_SIZE; i++) m_params[i] = (i < 14) ? d[i] : 8'h00;
    m_err = 1'b0;
    m_en  = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_params(input string tag);
    for (int i = 0; i < REG_SIZE; i++) begin
      tests_run++;
      if (params_w[i*8 +: 8] !== m_params[i]) begin
        tests_failed++;
        $display("FAIL %s params[%0d]: got %h expected %h", tag, i, params_w[i*8 +: 8], m_params[i]);
      end
    end
  endtask

  // Drain one frame; snap is the state expected to have been captured
  task automatic read_frame(input logic [47:0] snap, input int stall, input int inj_idx,
                            input logic [7:0] inj_byte);
    logic [7:0] e;
    int n;
    for (int k = 0; k < OUT_SIZE; k++) begin
      e = 8'((snap >> (8 * (OUT_SIZE - 1 - k))) & 48'hFF);
      n = (stall >= 0) ? stall : int'($urandom_range(0, 3));
      if (k == inj_idx && n == 0) n = 1;
      for (int s = 0; s < n; s++) begin
        tests_run++;
        if (tx_valid !== 1'b1 || tx_byte !== e) begin
          tests_failed++;
          $display("FAIL frame_stall byte%0d: got v=%b %h expected v=1 %h", k, tx_valid, tx_byte, e);
        end
        if (s == 0 && k == inj_idx) begin
          rx_valid = 1'b1;
          rx_byte  = inj_byte;
        end
        x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
        @(negedge clk);
        rx_valid = 1'b0;
      end
      tx_ready = 1'b1;
      tests_run++;
      if (tx_valid !== 1'b1 || tx_byte !== e) begin
        tests_failed++;
        $display("FAIL frame_hs byte%0d: got v=%b %h expected v=1 %h", k, tx_valid, tx_byte, e);
      end
      @(negedge clk);
      tx_ready = 1'b0;
    end
    tests_run++;
    if (tx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_end tx_valid: got %b expected 0", tx_valid);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    check_params("reset");
    tests_run++;
    if ({dda_en, err, dda_init, tx_valid, tx_byte} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset_outs: got en=%b err=%b init=%b v=%b b=%h expected 1 0 0 0 00",
               dda_en, err, dda_init, tx_valid, tx_byte);
    end
  endtask

  task automatic test_write();
    logic [7:0] a, d, j;
    send_byte(8'h57); send_byte(8'h0C); send_byte(8'h08);
    m_params[12] = 8'h08;
    check_params("write_c");
    send_byte(8'h57); send_byte(8'h0E); send_byte(8'hFF);
    m_err = 1'b1;
    check_params("write_oob");
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL oob_err: got %b expected 1", err); end
    send_byte(8'h45);
    m_err = 1'b0;
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL err_clear: got %b expected 0", err); end
`ifndef DDA_CTRL_STREAM_EN
    send_byte(8'h43);
    m_err = 1'b1;
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL c_unrec: got %b expected 1", err); end
`endif
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          a = 8'($urandom_range(0, REG_SIZE + 3));
          d = 8'($urandom);
          send_byte(8'h57); send_byte(a); send_byte(d);
          if (a < REG_SIZE) m_params[a] = d; else m_err = 1'b1;
        end
        2: begin
          j = 8'($urandom);
          if (j inside {8'h57, 8'h53, 8'h50, 8'h49, 8'h52, 8'h45, 8'h43}) j = 8'h00;
          send_byte(j);
          m_err = 1'b1;
        end
        default: begin
          send_byte(8'h45);
          m_err = 1'b0;
        end
      endcase
      check_params("rand_write");
      tests_run++;
      if (err !== m_err) begin
        tests_failed++;
        $display("FAIL rand_err it%0d: got %b expected %b", it, err, m_err);
      end
    end
    send_byte(8'h45);
    m_err = 1'b0;
  endtask

  task automatic test_run_ctrl();
    logic [7:0] c;
    send_byte(8'h50); m_en = 1'b0;
    tests_run++;
    if (dda_en !== 1'b0) begin tests_failed++; $display("FAIL en_p: got %b expected 0", dda_en); end
    send_byte(8'h49);
    tests_run++;
    if (dda_init !== 1'b1 || dda_en !== 1'b0) begin
      tests_failed++; $display("FAIL init_pulse: got init=%b en=%b expected 1 0", dda_init, dda_en);
    end
    @(negedge clk);
    tests_run++;
    if (dda_init !== 1'b0) begin tests_failed++; $display("FAIL init_end: got %b expected 0", dda_init); end
    send_byte(8'h53); m_en = 1'b1;
    tests_run++;
    if (dda_en !== 1'b1) begin tests_failed++; $display("FAIL en_s: got %b expected 1", dda_en); end
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 2))
        0:       c = 8'h53;
        1:       c = 8'h50;
        default: c = 8'h49;
      endcase
      send_byte(c);
      if (c == 8'h53) m_en = 1'b1;
      if (c == 8'h50) m_en = 1'b0;
      tests_run++;
      if (dda_en !== m_en || dda_init !== (c == 8'h49)) begin
        tests_failed++;
        $display("FAIL rand_ctrl %h: got en=%b init=%b expected en=%b init=%b",
                 c, dda_en, dda_init, m_en, c == 8'h49);
      end
    end
    send_byte(8'h53); m_en = 1'b1;
  endtask

  task automatic test_readout();
    logic [47:0] s;
    x = 16'hC000; y = 16'h14CD; z = 16'h7240;
    send_byte(8'h52);
    read_frame(48'hC000_14CD_7240, 3, -1, 8'h00);
    for (int f = 0; f < 4; f++) begin
      x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
      s = {x, y, z};
      send_byte(8'h52);
      read_frame(s, -1, -1, 8'h00);
    end
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL readout_err: got %b expected 0", err); end
  endtask

  task automatic test_overrun();
    logic [47:0] s;
    x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
    s = {x, y, z};
    send_byte(8'h52);
    read_frame(s, 1, int'($urandom_range(0, OUT_SIZE - 1)), 8'h57);
    m_err = 1'b1;
    tests_run++;
    if (err !== 1'b1) begin tests_failed++; $display("FAIL overrun_err: got %b expected 1", err); end
    check_params("overrun");
    send_byte(8'h45); m_err = 1'b0;
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hAA);
    m_params[3] = 8'hAA;
    check_params("post_overrun");
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL post_overrun_err: got %b expected 0", err); end
  endtask

  task automatic test_reset_abort();
    send_byte(8'h57); send_byte(8'h05);
    do_reset();
    send_byte(8'h45);
    check_params("abort_write");
    tests_run++;
    if (err !== 1'b0) begin tests_failed++; $display("FAIL abort_err: got %b expected 0", err); end
    x = 16'h1234; y = 16'h5678; z = 16'h9ABC;
    send_byte(8'h52);
    tests_run++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'h12) begin
      tests_failed++; $display("FAIL abort_first: got v=%b %h expected v=1 12", tx_valid, tx_byte);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tests_run++;
    if (tx_valid !== 1'b0 || tx_byte !== 8'h00) begin
      tests_failed++; $display("FAIL abort_frame: got v=%b %h expected v=0 00", tx_valid, tx_byte);
    end
  endtask

`ifdef DDA_CTRL_STREAM_EN
  task automatic test_stream();
    logic [47:0] s;
    logic [7:0] e;
    x = 16'($urandom); y = 16'($urandom); z = 16'($urandom);
    s = {x, y, z};
    tx_ready = 1'b1;
    send_byte(8'h43);
    tests_run++;
    if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_pre: got %b expected 0", tx_valid); end
    @(negedge clk);
    for (int k = 0; k < 3 * OUT_SIZE; k++) begin
      e = 8'((s >> (8 * (OUT_SIZE - 1 - (k % OUT_SIZE)))) & 48'hFF);
      tests_run++;
      if (tx_valid !== 1'b1 || tx_byte !== e) begin
        tests_failed++; $display("FAIL stream k%0d: got v=%b %h expected v=1 %h", k, tx_valid, tx_byte, e);
      end
      @(negedge clk);
    end
    send_byte(8'h50);
    for (int k = 1; k < OUT_SIZE; k++) begin
      e = 8'((s >> (8 * (OUT_SIZE - 1 - k))) & 48'hFF);
      tests_run++;
      if (tx_valid !== 1'b1 || tx_byte !== e) begin
        tests_failed++; $display("FAIL stream_tail k%0d: got v=%b %h expected v=1 %h", k, tx_valid, tx_byte, e);
      end
      @(negedge clk);
    end
    tests_run++;
    if (tx_valid !== 1'b0 || dda_en !== 1'b0 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_stop: got v=%b en=%b err=%b expected 0 0 0", tx_valid, dda_en, err);
    end
    tx_ready = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_ready = 1'b0;
    x = '0; y = '0; z = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_write();
    test_run_ctrl();
    test_readout();
    test_overrun();
    test_reset_abort();
`ifdef DDA_CTRL_STREAM_EN
    test_stream();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
